// File: rtl/mem_bus_ctrl.sv
// Arbitrates an instruction-fetch stream and a data load/store stream onto a
// single-port strobe/ack memory bus, returning completions as one-cycle ready pulses.
module mem_bus_ctrl #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_WORD = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imemRen,
  input  logic [31:0] imemaddr,
  input  logic        dmmRen,
  input  logic        dmmWen,
  input  logic [31:0] dmmaddr,
  input  logic [31:0] dmmstore,
  input  logic [1:0]  d_fetch,
  output logic [31:0] imemload,
  output logic [31:0] dmmload,
  output logic        i_ready,
  output logic        d_ready,
  output logic        d_misaligned,
  output logic        bus_timeout,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  output logic        bus_wen,
  output logic        bus_ren,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        is_d_q, is_d_d, is_w_q, is_w_d, last_d_q, last_d_d;
  logic [1:0]  size_q, size_d, off_q, off_d;
  logic [31:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic        bus_wen_q, bus_wen_d, bus_ren_q, bus_ren_d;
  logic [31:0] imemload_q, imemload_d, dmmload_q, dmmload_d;
  logic        i_ready_q, i_ready_d, d_ready_q, d_ready_d;
  logic        mis_q, mis_d, tout_q, tout_d;

  logic        pick_d, dmis;
  logic [1:0]  dsize;
  logic [3:0]  dsel;
  logic [31:0] dwdata, rshift, rlane, done_data;
  logic [7:0]  cnt_inc;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^imemaddr[1:0];

  // Data normally wins, but a fetch waiting behind a data completion goes next.
  assign pick_d  = (dmmRen | dmmWen) & ~(last_d_q & imemRen);
  assign dsize   = (d_fetch == 2'b11) ? 2'b10 : d_fetch;
  assign dmis    = ((dsize == 2'b01) & dmmaddr[0]) | ((dsize == 2'b10) & (|dmmaddr[1:0]));
  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    dsel   = 4'b1111;
    dwdata = dmmstore;
    case (dsize)
      2'b00: begin
        dsel   = 4'b0001 << dmmaddr[1:0];
        dwdata = {4{dmmstore[7:0]}};
      end
      2'b01: begin
        dsel   = dmmaddr[1] ? 4'b1100 : 4'b0011;
        dwdata = {2{dmmstore[15:0]}};
      end
      default: ;
    endcase
  end

  assign rshift = bus_rdata >> {off_q, 3'b000};
  always_comb begin
    case (size_q)
      2'b00:   rlane = {24'b0, rshift[7:0]};
      2'b01:   rlane = {16'b0, rshift[15:0]};
      default: rlane = rshift;
    endcase
  end
  assign done_data = bus_ack ? rlane : ERR_WORD;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_d_d      = is_d_q;
    is_w_d      = is_w_q;
    last_d_d    = last_d_q;
    size_d      = size_q;
    off_d       = off_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_sel_d   = bus_sel_q;
    bus_wen_d   = 1'b0;
    bus_ren_d   = 1'b0;
    imemload_d  = '0;
    dmmload_d   = '0;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    mis_d       = 1'b0;
    tout_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          is_d_d = 1'b1;
          is_w_d = dmmWen;
          size_d = dsize;
          off_d  = dmmaddr[1:0];
          if (dmis) begin
            state_d   = DONE;
            d_ready_d = 1'b1;
            mis_d     = 1'b1;
            last_d_d  = 1'b1;
          end else begin
            state_d     = ISSUE;
            bus_addr_d  = {dmmaddr[31:2], 2'b00};
            bus_sel_d   = dsel;
            bus_wdata_d = dwdata;
            bus_wen_d   = dmmWen;
            bus_ren_d   = ~dmmWen;
          end
        end else if (imemRen) begin
          state_d     = ISSUE;
          is_d_d      = 1'b0;
          is_w_d      = 1'b0;
          size_d      = 2'b10;
          off_d       = 2'b00;
          bus_addr_d  = {imemaddr[31:2], 2'b00};
          bus_sel_d   = 4'b1111;
          bus_wdata_d = '0;
          bus_ren_d   = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (bus_ack || (cnt_inc == TO_LIM)) begin
          state_d  = DONE;
          last_d_d = is_d_q;
          tout_d   = ~bus_ack;
          if (is_d_q) begin
            d_ready_d = 1'b1;
            dmmload_d = is_w_q ? '0 : done_data;
          end else begin
            i_ready_d  = 1'b1;
            imemload_d = done_data;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_d_q      <= 1'b0;
      is_w_q      <= 1'b0;
      last_d_q    <= 1'b0;
      size_q      <= '0;
      off_q       <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_sel_q   <= '0;
      bus_wen_q   <= 1'b0;
      bus_ren_q   <= 1'b0;
      imemload_q  <= '0;
      dmmload_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      mis_q       <= 1'b0;
      tout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_d_q      <= is_d_d;
      is_w_q      <= is_w_d;
      last_d_q    <= last_d_d;
      size_q      <= size_d;
      off_q       <= off_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_sel_q   <= bus_sel_d;
      bus_wen_q   <= bus_wen_d;
      bus_ren_q   <= bus_ren_d;
      imemload_q  <= imemload_d;
      dmmload_q   <= dmmload_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      mis_q       <= mis_d;
      tout_q      <= tout_d;
    end
  end

  assign imemload     = imemload_q;
  assign dmmload      = dmmload_q;
  assign i_ready      = i_ready_q;
  assign d_ready      = d_ready_q;
  assign d_misaligned = mis_q;
  assign bus_timeout  = tout_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign bus_sel      = bus_sel_q;
  assign bus_wen      = bus_wen_q;
  assign bus_ren      = bus_ren_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: expected bus strobes and ready responses are
// queued by the stimulus and popped by independent bus-model and monitor processes.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemRen, dmmRen, dmmWen;
  logic [31:0] imemaddr, dmmaddr, dmmstore;
  logic [1:0]  d_fetch;
  logic [31:0] imemload, dmmload, bus_addr, bus_wdata, bus_rdata;
  logic        i_ready, d_ready, d_misaligned, bus_timeout;
  logic [3:0]  bus_sel;
  logic        bus_wen, bus_ren, bus_ack;

  always #5 clk = ~clk;

  mem_bus_ctrl #(.TIMEOUT(4), .ERR_WORD(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst(rst),
    .imemRen(imemRen), .imemaddr(imemaddr),
    .dmmRen(dmmRen), .dmmWen(dmmWen), .dmmaddr(dmmaddr), .dmmstore(dmmstore), .d_fetch(d_fetch),
    .imemload(imemload), .dmmload(dmmload), .i_ready(i_ready), .d_ready(d_ready),
    .d_misaligned(d_misaligned), .bus_timeout(bus_timeout),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel),
    .bus_wen(bus_wen), .bus_ren(bus_ren), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  typedef struct {
    logic        is_d;
    logic [31:0] data;
    logic        mis;
    logic        tout;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } bus_t;

  resp_t resp_q[$];
  bus_t  bus_q[$];
  int    checks = 0;
  int    failures = 0;
  int    ack_delay = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_bus(input logic [31:0] a, input logic [3:0] s, input logic w,
                          input logic [31:0] wd, input logic [31:0] rd);
    bus_t e;
    e.addr = a; e.sel = s; e.wen = w; e.wdata = wd; e.rdata = rd;
    bus_q.push_back(e);
  endtask

  task automatic push_resp(input logic d, input logic [31:0] data, input logic m, input logic t);
    resp_t r;
    r.is_d = d; r.data = data; r.mis = m; r.tout = t;
    resp_q.push_back(r);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_loads"}, imemload | dmmload, 32'h0);
    chk({name, "_bus"}, bus_addr | bus_wdata, 32'h0);
    chk({name, "_ctl"}, {22'b0, bus_sel, bus_wen, bus_ren, i_ready, d_ready, d_misaligned, bus_timeout}, 32'h0);
  endtask

  // Waits for the selected ready pulse, checks latency, then steps to just after the edge ending DONE.
  task automatic wait_ready(input bit want_d, input int exp_lat, input string name);
    int cyc = 0;
    bit seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (want_d ? d_ready : i_ready) begin
        seen = 1;
        break;
      end
      cyc++;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_wait actual=no_ready required=ready_within_40_cycles", name);
    end else begin
      chk({name, "_latency"}, cyc, exp_lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic data_op(input logic ren, input logic wen, input logic [31:0] addr,
                         input logic [31:0] store, input logic [1:0] fetch,
                         input int lat, input string name);
    dmmRen = ren; dmmWen = wen; dmmaddr = addr; dmmstore = store; d_fetch = fetch;
    wait_ready(1'b1, lat, name);
    dmmRen = 1'b0; dmmWen = 1'b0;
  endtask

  // Bus slave: checks every strobe against the queue and acks ack_delay cycles later (0 = never).
  initial begin
    int          pend;
    logic [31:0] rd;
    logic        prev;
    bus_t        e;
    pend = 0; rd = '0; prev = 1'b0;
    bus_ack = 1'b0; bus_rdata = 32'hFFFF_FFFF;
    forever begin
      @(posedge clk);
      #1;
      bus_ack   = (pend == 1);
      bus_rdata = (pend == 1) ? rd : 32'hFFFF_FFFF;
      if (pend > 0) pend--;
      @(negedge clk);
      if (prev) chk("strobe_one_cycle", {31'b0, bus_ren | bus_wen}, 32'h0);
      prev = bus_ren | bus_wen;
      if (prev) begin
        if (bus_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe actual=addr_%h required=no_strobe", bus_addr);
        end else begin
          e = bus_q.pop_front();
          $display("bus  addr=%h sel=%b wen=%0d wdata=%h", bus_addr, bus_sel, bus_wen, bus_wdata);
          chk("bus_addr", bus_addr, e.addr);
          chk("bus_sel", {28'b0, bus_sel}, {28'b0, e.sel});
          chk("bus_kind", {30'b0, bus_wen, bus_ren}, {30'b0, e.wen, ~e.wen});
          chk("bus_wdata", bus_wdata, e.wdata);
          rd   = e.rdata;
          pend = ack_delay;
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    resp_t r;
    if (!rst) begin
      if (i_ready || d_ready) begin
        if (resp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ready actual=i%0d_d%0d required=none", i_ready, d_ready);
        end else begin
          r = resp_q.pop_front();
          $display("resp %s data=%h mis=%0d tout=%0d", d_ready ? "D" : "I",
                   d_ready ? dmmload : imemload, d_misaligned, bus_timeout);
          chk("resp_kind", {30'b0, i_ready, d_ready}, {30'b0, ~r.is_d, r.is_d});
          chk("resp_data", r.is_d ? dmmload : imemload, r.data);
          chk("resp_other_load", r.is_d ? imemload : dmmload, 32'h0);
          chk("resp_flags", {30'b0, d_misaligned, bus_timeout}, {30'b0, r.mis, r.tout});
        end
      end else begin
        chk("quiet_outputs", imemload | dmmload | {30'b0, d_misaligned, bus_timeout}, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    imemRen = 1'b0; imemaddr = '0; dmmRen = 1'b0; dmmWen = 1'b0;
    dmmaddr = '0; dmmstore = '0; d_fetch = 2'b00;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    push_bus(32'h100, 4'b1111, 1'b0, 32'h0, 32'h1234_5678);
    push_resp(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    data_op(1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 3, "word_load");

    push_bus(32'h200, 4'b1000, 1'b1, 32'hABAB_ABAB, 32'h0);
    push_resp(1'b1, 32'h0, 1'b0, 1'b0);
    data_op(1'b0, 1'b1, 32'h203, 32'h0000_00AB, 2'b00, 3, "byte_store");

    push_bus(32'h100, 4'b1100, 1'b0, 32'h0, 32'hBEEF_1234);
    push_resp(1'b1, 32'h0000_BEEF, 1'b0, 1'b0);
    data_op(1'b1, 1'b0, 32'h102, 32'h0, 2'b01, 3, "half_load");

    push_resp(1'b1, 32'h0, 1'b1, 1'b0);
    data_op(1'b1, 1'b0, 32'h101, 32'h0, 2'b01, 1, "half_misaligned");

    push_bus(32'h100, 4'b0010, 1'b0, 32'h0, 32'h1122_3344);
    push_resp(1'b1, 32'h0000_0033, 1'b0, 1'b0);
    data_op(1'b1, 1'b0, 32'h101, 32'h0, 2'b00, 3, "byte_load_lane1");

    push_bus(32'h304, 4'b1100, 1'b1, 32'h5A5A_5A5A, 32'h0);
    push_resp(1'b1, 32'h0, 1'b0, 1'b0);
    data_op(1'b0, 1'b1, 32'h306, 32'hFFFF_5A5A, 2'b01, 3, "half_store");

    push_resp(1'b1, 32'h0, 1'b1, 1'b0);
    data_op(1'b0, 1'b1, 32'h102, 32'h1111_2222, 2'b10, 1, "word_store_misaligned");

    push_bus(32'h108, 4'b1111, 1'b0, 32'h0, 32'hCAFE_F00D);
    push_resp(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0);
    data_op(1'b1, 1'b0, 32'h108, 32'h0, 2'b11, 3, "size11_load");

    push_bus(32'h10C, 4'b1111, 1'b1, 32'hA5A5_0001, 32'h0);
    push_resp(1'b1, 32'h0, 1'b0, 1'b0);
    data_op(1'b1, 1'b1, 32'h10C, 32'hA5A5_0001, 2'b10, 3, "ren_wen_write_wins");

    push_bus(32'h1000, 4'b1111, 1'b0, 32'h0, 32'h0000_0013);
    push_resp(1'b0, 32'h0000_0013, 1'b0, 1'b0);
    imemRen = 1'b1; imemaddr = 32'h1003;
    wait_ready(1'b0, 3, "fetch");
    imemRen = 1'b0;

    push_bus(32'h300, 4'b1111, 1'b0, 32'h0, 32'h1111_1111);
    push_bus(32'h2000, 4'b1111, 1'b0, 32'h0, 32'h0BAD_C0DE);
    push_bus(32'h304, 4'b1111, 1'b0, 32'h0, 32'h2222_2222);
    push_resp(1'b1, 32'h1111_1111, 1'b0, 1'b0);
    push_resp(1'b0, 32'h0BAD_C0DE, 1'b0, 1'b0);
    push_resp(1'b1, 32'h2222_2222, 1'b0, 1'b0);
    imemRen = 1'b1; imemaddr = 32'h2000;
    dmmRen = 1'b1; dmmaddr = 32'h300; dmmstore = 32'h0; d_fetch = 2'b10;
    wait_ready(1'b1, 3, "both_data_first");
    dmmaddr = 32'h304;
    wait_ready(1'b0, 3, "both_fetch_second");
    imemRen = 1'b0;
    wait_ready(1'b1, 3, "both_data_again");
    dmmRen = 1'b0;

    ack_delay = 0;
    push_bus(32'h400, 4'b1111, 1'b0, 32'h0, 32'h0);
    push_resp(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    data_op(1'b1, 1'b0, 32'h400, 32'h0, 2'b10, 6, "timeout");

    ack_delay = 3;
    push_bus(32'h500, 4'b1111, 1'b0, 32'h0, 32'h5555_5555);
    dmmRen = 1'b1; dmmaddr = 32'h500; d_fetch = 2'b10;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus_ren) break;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    dmmRen = 1'b0;
    @(negedge clk);
    check_all_zero("rst_in_wait");
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ack_delay = 1;
    push_bus(32'h600, 4'b1111, 1'b0, 32'h0, 32'h600D_0001);
    push_resp(1'b1, 32'h600D_0001, 1'b0, 1'b0);
    data_op(1'b1, 1'b0, 32'h600, 32'h0, 2'b10, 3, "after_reset");

    repeat (5) @(negedge clk);
    chk("resp_queue_drained", resp_q.size(), 32'h0);
    chk("bus_queue_drained", bus_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
